button_conditioner: RTL and testbench

// - Input-side counterpart of the display scan path: the display block drives the anodes
//   out; this block conditions the alarm-clock push-buttons coming in.
// - Per button: 2-FF synchroniser, debounce FSM, and press/release pulses.
// - Also generates an auto-repeat strobe for time/alarm setting.
// - Runs on the 1 kHz scan clock, so 1 cycle = 1 ms; every duration parameter is in ms.

---
 rtl/btn_pkg.sv | 28 ++
 rtl/btn_channel.sv | 156 +++++++++++++++
 rtl/button_conditioner.sv | 49 ++++
 tb/tb_button_conditioner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning path.
//   - btn_state_t : per-button debounce / auto-repeat FSM state (3-bit)
//   - *_DEF       : default timing constants, in 1 kHz clock cycles (= ms)
//   - max3        : helper used to size the shared per-channel counter
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,  // released, level 0
    DB_DN   = 3'd1,  // candidate press being debounced
    PRESSED = 3'd2,  // accepted press, timing the initial hold
    HELD    = 3'd3,  // auto-repeat running
    DB_UP   = 3'd4   // candidate release being debounced, level still 1
  } btn_state_t;

  localparam int DEBOUNCE_MS_DEF = 20;
  localparam int HOLD_MS_DEF     = 600;
  localparam int REPEAT_MS_DEF   = 150;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// Conditions a single push-button: 2-FF synchroniser, debounce FSM with
// press/release pulses, and an auto-repeat strobe.
// Ports:
//   clk_1khz      in  1 kHz clock, all logic on posedge
//   rst_n         in  asynchronous active-low reset
//   raw           in  raw asynchronous button, active-high
//   level         out debounced level
//   press_pulse   out 1-cycle pulse on accepted press
//   release_pulse out 1-cycle pulse on accepted release
//   repeat_pulse  out 1-cycle pulse at press, press+HOLD_MS, then every REPEAT_MS
// -----------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int HOLD_MS     = HOLD_MS_DEF,
  parameter int REPEAT_MS   = REPEAT_MS_DEF
) (
  input  logic clk_1khz,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  // Only one duration is ever being timed per state, so a single counter
  // serves as debounce, hold and repeat timer; it is cleared on every state
  // entry and stops at its terminal value, so it never wraps.
  localparam int CNT_MAX = max3(DEBOUNCE_MS, HOLD_MS, REPEAT_MS);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             s1_reg, s2_reg;
  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             repeat_reg, repeat_next;

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
    end else begin
      s1_reg      <= raw;
      s2_reg      <= s1_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      repeat_reg  <= repeat_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        level_next = 1'b0;
        if (s2_reg) begin
          state_next = DB_DN;
          cnt_next   = '0;
        end
      end

      DB_DN: begin
        if (!s2_reg) begin
          state_next = IDLE;            // glitch shorter than debounce window
        end else if (cnt_reg == DB_LAST) begin
          state_next  = PRESSED;
          cnt_next    = '0;
          level_next  = 1'b1;
          press_next  = 1'b1;
          repeat_next = 1'b1;           // first repeat coincides with press
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!s2_reg) begin
          state_next = DB_UP;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next  = HELD;
          cnt_next    = '0;
          repeat_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      HELD: begin
        if (!s2_reg) begin
          state_next = DB_UP;
          cnt_next   = '0;
        end else if (cnt_reg == REP_LAST) begin
          cnt_next    = '0;
          repeat_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DB_UP: begin
        if (s2_reg) begin
          // Release bounce: back to PRESSED with hold timing restarted,
          // so auto-repeat never fires off a bouncing contact.
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == DB_LAST) begin
          state_next   = IDLE;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign level         = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign repeat_pulse  = repeat_reg;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions the alarm-clock push-buttons: one independent btn_channel per
// button, outputs gathered into bit vectors.
// Ports:
//   clk_1khz    in  1 kHz scan clock (1 cycle = 1 ms)
//   rst_n       in  asynchronous active-low reset
//   btn_raw     in  [N_BTN] raw asynchronous buttons, active-high
//   btn_level   out [N_BTN] debounced level
//   btn_press   out [N_BTN] 1-cycle pulse on accepted press
//   btn_release out [N_BTN] 1-cycle pulse on accepted release
//   btn_repeat  out [N_BTN] auto-repeat strobe
// -----------------------------------------------------------------------------
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int HOLD_MS     = HOLD_MS_DEF,
  parameter int REPEAT_MS   = REPEAT_MS_DEF
) (
  input  logic             clk_1khz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_channel #(
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .HOLD_MS     (HOLD_MS),
        .REPEAT_MS   (REPEAT_MS)
      ) u_ch (
        .clk_1khz      (clk_1khz),
        .rst_n         (rst_n),
        .raw           (btn_raw[gi]),
        .level         (btn_level[gi]),
        .press_pulse   (btn_press[gi]),
        .release_pulse (btn_release[gi]),
        .repeat_pulse  (btn_repeat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk_1khz = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

  button_conditioner #(
    .N_BTN(4), .DEBOUNCE_MS(20), .HOLD_MS(600), .REPEAT_MS(150)
  ) dut (
    .clk_1khz    (clk_1khz),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  always #5 clk_1khz = ~clk_1khz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int press_cnt[4];
  int rel_cnt[4];
  int rpt_cnt[4];
  int last_press = 0;
  int rep_q[$];

  typedef struct {
    logic [3:0] raw;
    int         ncyc;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
    int         press_cnt0;
    int         rel_cnt0;
    int         rpt_cnt0;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  // One edge, then sample 1 time unit later and tally pulses.
  task automatic tick();
    @(posedge clk_1khz);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (btn_press[i])   press_cnt[i]++;
      if (btn_release[i]) rel_cnt[i]++;
      if (btn_repeat[i])  rpt_cnt[i]++;
    end
    if (btn_repeat[0]) rep_q.push_back(cyc);
    if (btn_press[0])  last_press = cyc;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    int p;
    int rel_before, press_before;
    int exp_off[4];

    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; rpt_cnt[i] = 0;
    end

    // raw, ncyc, level, press, rel, rpt, cumulative btn0 press/release/repeat
    // clean press (100 cycles) and release
    vecs[0]  = '{4'b0001, 22, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0};
    vecs[1]  = '{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1};
    vecs[2]  = '{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1};
    vecs[3]  = '{4'b0001, 76, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1};
    vecs[4]  = '{4'b0000, 22, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1};
    vecs[5]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 1, 1};
    vecs[6]  = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1};
    // glitch: 10 cycles high is shorter than the debounce window
    vecs[7]  = '{4'b0001, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1};
    vecs[8]  = '{4'b0000, 30, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1};
    // press, then release bounce 5 cycles per phase for 30 cycles
    vecs[9]  = '{4'b0001, 23, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2, 1, 2};
    vecs[10] = '{4'b0001,  7, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1, 2};
    vecs[11] = '{4'b0000,  5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1, 2};
    vecs[12] = '{4'b0001,  5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1, 2};
    vecs[13] = '{4'b0000,  5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1, 2};
    vecs[14] = '{4'b0001,  5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1, 2};
    vecs[15] = '{4'b0000,  5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1, 2};
    vecs[16] = '{4'b0001,  5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1, 2};
    // final fall: single release 22 edges after its first sample
    vecs[17] = '{4'b0000, 22, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1, 2};
    vecs[18] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 2, 2, 2};
    vecs[19] = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 2, 2};

    // ---- reset ----
    btn_raw = 4'b0000;
    rst_n   = 1'b0;
    #1;
    check("reset_level",   int'(btn_level),   0);
    check("reset_press",   int'(btn_press),   0);
    check("reset_release", int'(btn_release), 0);
    check("reset_repeat",  int'(btn_repeat),  0);
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    $display("reset: level=%b press=%b release=%b repeat=%b",
             btn_level, btn_press, btn_release, btn_repeat);

    // ---- table-driven sequences ----
    for (int v = 0; v < NVEC; v++) begin
      btn_raw = vecs[v].raw;
      ticks(vecs[v].ncyc);
      $display("vec %0d: raw=%b +%0d cyc level=%b press=%b release=%b repeat=%b",
               v, vecs[v].raw, vecs[v].ncyc, btn_level, btn_press, btn_release, btn_repeat);
      check($sformatf("vec%0d_level", v),   int'(btn_level),   int'(vecs[v].level));
      check($sformatf("vec%0d_press", v),   int'(btn_press),   int'(vecs[v].press));
      check($sformatf("vec%0d_release", v), int'(btn_release), int'(vecs[v].rel));
      check($sformatf("vec%0d_repeat", v),  int'(btn_repeat),  int'(vecs[v].rpt));
      check($sformatf("vec%0d_press_cnt", v),   press_cnt[0], vecs[v].press_cnt0);
      check($sformatf("vec%0d_release_cnt", v), rel_cnt[0],   vecs[v].rel_cnt0);
      check($sformatf("vec%0d_repeat_cnt", v),  rpt_cnt[0],   vecs[v].rpt_cnt0);
    end

    // ---- long hold: repeats at P, P+600, P+750, P+900 ----
    exp_off = '{0, 600, 750, 900};
    rep_q.delete();
    rel_before = rel_cnt[0];
    p = cyc;
    btn_raw = 4'b0001;
    ticks(1000);
    check("hold_press_latency", last_press - p, 23);
    check("hold_repeat_total", rep_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rep_q.size())
        check($sformatf("hold_repeat%0d_offset", i), rep_q[i] - last_press, exp_off[i]);
    end
    btn_raw = 4'b0000;
    ticks(30);
    check("hold_release_cnt", rel_cnt[0] - rel_before, 1);
    check("hold_repeat_after_release", rep_q.size(), 4);
    check("hold_level_after", int'(btn_level), 0);
    $display("long hold: repeats=%0d releases=%0d", rep_q.size(), rel_cnt[0] - rel_before);

    // ---- reset mid-hold ----
    btn_raw = 4'b0001;
    ticks(23);
    check("rst_hold_press", int'(btn_press[0]), 1);
    ticks(700);
    rel_before   = rel_cnt[0];
    rst_n = 1'b0;
    #1;
    check("rst_hold_level",   int'(btn_level),   0);
    check("rst_hold_press0",  int'(btn_press),   0);
    check("rst_hold_release", int'(btn_release), 0);
    check("rst_hold_repeat",  int'(btn_repeat),  0);
    ticks(3);
    rst_n = 1'b1;
    press_before = press_cnt[0];
    ticks(22);
    check("rst_hold_no_early_press", press_cnt[0] - press_before, 0);
    tick();
    check("rst_hold_new_press", int'(btn_press[0]), 1);
    check("rst_hold_new_level", int'(btn_level[0]), 1);
    check("rst_hold_no_release", rel_cnt[0] - rel_before, 0);
    $display("reset mid-hold: new press at +23, releases=%0d", rel_cnt[0] - rel_before);
    btn_raw = 4'b0000;
    ticks(30);

    // ---- multi-button ----
    rel_before = rel_cnt[0];
    btn_raw = 4'b0101;
    ticks(22);
    check("multi_no_early_press", int'(btn_press), 0);
    tick();
    check("multi_press", int'(btn_press), 5);
    check("multi_level", int'(btn_level), 5);
    ticks(27);
    btn_raw = 4'b0001;
    ticks(22);
    check("multi_no_early_release", int'(btn_release), 0);
    tick();
    check("multi_release", int'(btn_release), 4);
    check("multi_level_after", int'(btn_level), 1);
    ticks(5);
    check("multi_btn0_no_release", rel_cnt[0] - rel_before, 0);
    check("multi_btn2_release_cnt", rel_cnt[2], 1);
    $display("multi-button: level=%b btn2 releases=%0d", btn_level, rel_cnt[2]);
    btn_raw = 4'b0000;
    ticks(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
